vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in pixels.
REQ-004 Parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 Parameter V_FP, 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, 2, vsync pulse width in lines.
REQ-008 Parameter V_BP, 33, vertical back porch in lines.
REQ-009 Parameter SYNC_POL, 0, asserted sync level; 0 = active low.
REQ-010 Parameter COLOR_W, 8, bits per colour channel.
REQ-011 Parameter CNT_W, 11, counter width; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP SHALL fit in CNT_W bits.
REQ-012 clk  in  1  single system clock; all state changes on its rising edge.
REQ-013 rst  in  1  asynchronous, active-high reset.
REQ-014 pix_en  in  1  pixel strobe; one pixel period per clk cycle with pix_en=1.
REQ-015 enable  in  1  timing run enable.
REQ-016 in_r, in_g, in_b  in  COLOR_W each  pixel data returned by the source.
REQ-017 hcount, vcount  out  CNT_W each  coordinate of the pixel currently requested.
REQ-018 req  out  1  high when (hcount,vcount) is inside the visible area.
REQ-019 frame_start, line_start  out  1 each  single-clk pulses.
REQ-020 hsync, vsync, de  out  1 each  registered sync and data-enable.
REQ-021 VGA_R, VGA_G, VGA_B  out  COLOR_W each  registered pixel outputs.

Function
REQ-022 Counters SHALL advance only on clk edges with pix_en=1 and enable=1; otherwise they hold.
REQ-023 hcount SHALL wrap from H_TOTAL-1 to 0; vcount SHALL increment only on that wrap and wrap from V_TOTAL-1 to 0.
REQ-024 req SHALL be combinational: hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-025 The source SHALL present data for the pixel requested at strobe k on in_* at strobe k+1; in_* are sampled only on strobes.
REQ-026 Latency: hsync/vsync/de/VGA_* for pixel (h,v) SHALL update on the strobe edge after counters held (h,v), i.e. exactly one pixel period; flags pass through one delay register.
REQ-027 hsync asserted (level SYNC_POL) for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], else ~SYNC_POL.
REQ-028 vsync asserted (level SYNC_POL) for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], else ~SYNC_POL.
REQ-029 de SHALL equal the delayed req; VGA_* SHALL equal in_* when delayed req=1, else 0, regardless of in_*.
REQ-030 Outputs SHALL hold their value between strobes.
REQ-031 line_start SHALL pulse for one clk when pix_en=1, enable=1, hcount=0; frame_start additionally requires vcount=0.
REQ-032 enable=0 SHALL, on the next clk edge (independent of pix_en), clear counters to (0,0) and drive outputs idle; on re-enable the first strobe processes (0,0) and pulses frame_start.

Reset
REQ-033 rst=1 SHALL immediately force hcount=vcount=0, hsync=vsync=~SYNC_POL, de=0, VGA_*=0, pulses=0, delay registers idle, including mid-frame.
REQ-034 After rst release, first strobe with enable=1 SHALL process (0,0) and pulse frame_start.

Verification
REQ-035 Reset at (300,200) mid-line -> same-cycle hcount=vcount=0, hsync=vsync=1, de=0, VGA_*=0.
REQ-036 Defaults, pix_en=1 continuous -> de high 640 strobes per line; hsync low 96 strobes, falling on edge after hcount=656; vsync low for 2 lines (1600 strobes).
REQ-037 Counters at (799,524) plus one strobe -> (0,0), frame_start=1 for one clk; consecutive frame_start pulses 420000 strobes apart.
REQ-038 pix_en high every second clk -> counters and outputs change only on strobe cycles; frame period 840000 clks.
REQ-039 in_r=0xAA while req, 0xFF during blanking -> VGA_R=0xAA while de=1, 0x00 while de=0; one-strobe alignment with req.
REQ-040 H_ACTIVE=4,H_FP=1,H_SYNC=2,H_BP=1,V_ACTIVE=2,V_FP=1,V_SYNC=1,V_BP=1,SYNC_POL=1 -> 8-strobe lines, 5-line frames, hsync high at h=5,6, vsync high on line 3; mid-run enable=0 -> idle outputs, restart at (0,0).

Source files
------------

// File: rtl/vga_timing_if.sv
`timescale 1ns/1ps
// vga_timing_if -- bundle between the VGA timing generator and its pixel
// source / display sink.
//   pix_en, enable        : pixel strobe and run enable into the generator
//   in_r/in_g/in_b        : pixel data returned by the source
//   hcount, vcount, req   : coordinate currently requested and visible flag
//   frame_start/line_start: single-clk pulses on the (0,0) / (0,v) strobe
//   hsync, vsync, de      : registered sync and data-enable
//   VGA_R/VGA_G/VGA_B     : registered pixel outputs
// master = the timing generator, slave = the source/sink side.
interface vga_timing_if #(
  parameter int COLOR_W = 8,
  parameter int CNT_W   = 11
);
  logic               pix_en;
  logic               enable;
  logic [COLOR_W-1:0] in_r;
  logic [COLOR_W-1:0] in_g;
  logic [COLOR_W-1:0] in_b;
  logic [CNT_W-1:0]   hcount;
  logic [CNT_W-1:0]   vcount;
  logic               req;
  logic               frame_start;
  logic               line_start;
  logic               hsync;
  logic               vsync;
  logic               de;
  logic [COLOR_W-1:0] VGA_R;
  logic [COLOR_W-1:0] VGA_G;
  logic [COLOR_W-1:0] VGA_B;

  modport master (
    input  pix_en, enable, in_r, in_g, in_b,
    output hcount, vcount, req, frame_start, line_start,
           hsync, vsync, de, VGA_R, VGA_G, VGA_B
  );

  modport slave (
    output pix_en, enable, in_r, in_g, in_b,
    input  hcount, vcount, req, frame_start, line_start,
           hsync, vsync, de, VGA_R, VGA_G, VGA_B
  );
endinterface

// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen -- VGA raster timing generator with one-pixel output stage.
//   clk  : system clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset
//   bus  : vga_timing_if.master (strobe/enable and source data in;
//          coordinate, req, pulses, syncs, de and colour out)
// The counters name the pixel requested from the source. The source answers
// by the next strobe edge, where the colour is registered together with the
// sync/de flags computed from the same coordinate, so all outputs for pixel
// (h,v) appear exactly one pixel period after the counters held (h,v).
// H_TOTAL and V_TOTAL must fit in CNT_W bits.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 11
) (
  input logic         clk,
  input logic         rst,
  vga_timing_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  function automatic logic hsync_level(input logic [CNT_W-1:0] h);
    return ((h >= HS_BEG) && (h < HS_END)) ? SYNC_POL : ~SYNC_POL;
  endfunction

  function automatic logic vsync_level(input logic [CNT_W-1:0] v);
    return ((v >= VS_BEG) && (v < VS_END)) ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   v_cnt;
  logic               req_c;
  logic               strobe;
  logic               at_line0;

  logic               vld_p0;
  logic               hsync_p0;
  logic               vsync_p0;
  logic [COLOR_W-1:0] r_p0;
  logic [COLOR_W-1:0] g_p0;
  logic [COLOR_W-1:0] b_p0;

  assign strobe   = bus.pix_en & bus.enable;
  assign req_c    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign at_line0 = (h_cnt == '0);

  // Coordinate counters: dropping enable parks them at (0,0) so the next
  // run starts a fresh frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!bus.enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (bus.pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // ---- stage p0: flags for the held coordinate meet the source's data ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      hsync_p0 <= ~SYNC_POL;
      vsync_p0 <= ~SYNC_POL;
      r_p0     <= '0;
      g_p0     <= '0;
      b_p0     <= '0;
    end else if (!bus.enable) begin
      vld_p0   <= 1'b0;
      hsync_p0 <= ~SYNC_POL;
      vsync_p0 <= ~SYNC_POL;
      r_p0     <= '0;
      g_p0     <= '0;
      b_p0     <= '0;
    end else if (bus.pix_en) begin
      vld_p0   <= req_c;
      hsync_p0 <= hsync_level(h_cnt);
      vsync_p0 <= vsync_level(v_cnt);
      r_p0     <= req_c ? bus.in_r : '0;
      g_p0     <= req_c ? bus.in_g : '0;
      b_p0     <= req_c ? bus.in_b : '0;
    end
  end

  assign bus.hcount      = h_cnt;
  assign bus.vcount      = v_cnt;
  assign bus.req         = req_c;
  // Pulses are qualified by rst so they drop in the same cycle reset rises.
  assign bus.line_start  = strobe & ~rst & at_line0;
  assign bus.frame_start = strobe & ~rst & at_line0 & (v_cnt == '0);
  assign bus.de          = vld_p0;
  assign bus.hsync       = hsync_p0;
  assign bus.vsync       = vsync_p0;
  assign bus.VGA_R       = r_p0;
  assign bus.VGA_G       = g_p0;
  assign bus.VGA_B       = b_p0;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
module tb_vga_timing_gen;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  vga_timing_if #(.COLOR_W(8), .CNT_W(11)) bus_d ();
  vga_timing_if #(.COLOR_W(8), .CNT_W(11)) bus_s ();

  // Default 640x480 timing.
  vga_timing_gen dut_d (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  // Tiny timing: 8-pixel lines, 5-line frames, active-high syncs.
  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b1), .COLOR_W(8), .CNT_W(11)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  // Sources: default one returns the coordinate as colour; the tiny one
  // returns 0xAA for visible requests and 0xFF during blanking.
  assign bus_d.in_r = bus_d.hcount[7:0];
  assign bus_d.in_g = bus_d.vcount[7:0];
  assign bus_d.in_b = 8'h3C;
  assign bus_s.in_r = bus_s.req ? 8'hAA : 8'hFF;
  assign bus_s.in_g = 8'h11;
  assign bus_s.in_b = 8'h22;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_d.enable = 1'b1;
    bus_d.pix_en = 1'b1;
    bus_s.enable = 1'b0;
    bus_s.pix_en = 1'b0;
    repeat (3) tick();
    tests++; if (bus_d.hcount !== 11'd0) begin fails++; $display("FAIL reset_hcount: got %0d expected 0", bus_d.hcount); end
    tests++; if (bus_d.vcount !== 11'd0) begin fails++; $display("FAIL reset_vcount: got %0d expected 0", bus_d.vcount); end
    tests++; if (bus_d.hsync !== 1'b1) begin fails++; $display("FAIL reset_hsync: got %b expected 1", bus_d.hsync); end
    tests++; if (bus_d.vsync !== 1'b1) begin fails++; $display("FAIL reset_vsync: got %b expected 1", bus_d.vsync); end
    tests++; if (bus_d.de !== 1'b0) begin fails++; $display("FAIL reset_de: got %b expected 0", bus_d.de); end
    tests++; if (bus_d.VGA_R !== 8'h00) begin fails++; $display("FAIL reset_vga_r: got %h expected 00", bus_d.VGA_R); end
    tests++; if (bus_d.frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %b expected 0", bus_d.frame_start); end
    tests++; if (bus_d.line_start !== 1'b0) begin fails++; $display("FAIL reset_line_start: got %b expected 0", bus_d.line_start); end
    tests++; if (bus_s.hsync !== 1'b0) begin fails++; $display("FAIL reset_small_hsync: got %b expected 0", bus_s.hsync); end
    tests++; if (bus_s.vsync !== 1'b0) begin fails++; $display("FAIL reset_small_vsync: got %b expected 0", bus_s.vsync); end
  endtask

  task automatic test_first_strobe();
    rst = 1'b0;
    #1;
    tests++; if (bus_d.frame_start !== 1'b1) begin fails++; $display("FAIL first_frame_start: got %b expected 1", bus_d.frame_start); end
    tests++; if (bus_d.line_start !== 1'b1) begin fails++; $display("FAIL first_line_start: got %b expected 1", bus_d.line_start); end
    tests++; if (bus_d.req !== 1'b1) begin fails++; $display("FAIL first_req: got %b expected 1", bus_d.req); end
    tick();
    tests++; if (bus_d.hcount !== 11'd1) begin fails++; $display("FAIL first_hcount: got %0d expected 1", bus_d.hcount); end
    tests++; if (bus_d.de !== 1'b1) begin fails++; $display("FAIL first_de: got %b expected 1", bus_d.de); end
    tests++; if (bus_d.frame_start !== 1'b0) begin fails++; $display("FAIL first_frame_start_drop: got %b expected 0", bus_d.frame_start); end
  endtask

  // One full line at continuous strobes; sample i shows outputs for pixel i.
  task automatic test_hline();
    int de_cnt, hs_cnt, vs_cnt, ls_cnt, fs_cnt, first_hs;
    logic [7:0] r100, r700;
    de_cnt = 0; hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0; first_hs = -1;
    r100 = 8'h00; r700 = 8'hFF;
    for (int i = 0; i < 800; i++) begin
      if (bus_d.de === 1'b1) de_cnt++;
      if (bus_d.hsync === 1'b0) begin
        hs_cnt++;
        if (first_hs < 0) first_hs = i;
      end
      if (bus_d.vsync === 1'b0) vs_cnt++;
      if (bus_d.line_start === 1'b1) ls_cnt++;
      if (bus_d.frame_start === 1'b1) fs_cnt++;
      if (i == 100) r100 = bus_d.VGA_R;
      if (i == 700) r700 = bus_d.VGA_R;
      if (i == 799) begin
        tests++; if (bus_d.hcount !== 11'd0) begin fails++; $display("FAIL hline_wrap_h: got %0d expected 0", bus_d.hcount); end
        tests++; if (bus_d.vcount !== 11'd1) begin fails++; $display("FAIL hline_wrap_v: got %0d expected 1", bus_d.vcount); end
      end
      tick();
    end
    tests++; if (de_cnt != 640) begin fails++; $display("FAIL hline_de_count: got %0d expected 640", de_cnt); end
    tests++; if (hs_cnt != 96) begin fails++; $display("FAIL hline_hsync_count: got %0d expected 96", hs_cnt); end
    tests++; if (first_hs != 656) begin fails++; $display("FAIL hline_hsync_start: got pixel %0d expected 656", first_hs); end
    tests++; if (vs_cnt != 0) begin fails++; $display("FAIL hline_vsync: got %0d low samples expected 0", vs_cnt); end
    tests++; if (ls_cnt != 1) begin fails++; $display("FAIL hline_line_start: got %0d pulses expected 1", ls_cnt); end
    tests++; if (fs_cnt != 0) begin fails++; $display("FAIL hline_frame_start: got %0d pulses expected 0", fs_cnt); end
    tests++; if (r100 !== 8'd100) begin fails++; $display("FAIL hline_pixel100: got %0d expected 100", r100); end
    tests++; if (r700 !== 8'h00) begin fails++; $display("FAIL hline_blank_color: got %h expected 00", r700); end
  endtask

  task automatic test_mid_reset();
    for (int n = 0; n < 3000 && !(bus_d.hcount == 11'd300 && bus_d.vcount == 11'd2); n++) tick();
    tests++;
    if (!(bus_d.hcount === 11'd300 && bus_d.vcount === 11'd2)) begin
      fails++; $display("FAIL midrst_reach: got (%0d,%0d) expected (300,2)", bus_d.hcount, bus_d.vcount);
    end
    tests++; if (bus_d.de !== 1'b1) begin fails++; $display("FAIL midrst_pre_de: got %b expected 1", bus_d.de); end
    tests++; if (bus_d.VGA_R !== 8'h2B) begin fails++; $display("FAIL midrst_pre_r: got %h expected 2b", bus_d.VGA_R); end
    tests++; if (bus_d.VGA_G !== 8'h02) begin fails++; $display("FAIL midrst_pre_g: got %h expected 02", bus_d.VGA_G); end
    #1 rst = 1'b1;
    #1;
    tests++; if (bus_d.hcount !== 11'd0) begin fails++; $display("FAIL midrst_hcount: got %0d expected 0", bus_d.hcount); end
    tests++; if (bus_d.vcount !== 11'd0) begin fails++; $display("FAIL midrst_vcount: got %0d expected 0", bus_d.vcount); end
    tests++; if (bus_d.hsync !== 1'b1) begin fails++; $display("FAIL midrst_hsync: got %b expected 1", bus_d.hsync); end
    tests++; if (bus_d.vsync !== 1'b1) begin fails++; $display("FAIL midrst_vsync: got %b expected 1", bus_d.vsync); end
    tests++; if (bus_d.de !== 1'b0) begin fails++; $display("FAIL midrst_de: got %b expected 0", bus_d.de); end
    tests++; if (bus_d.VGA_R !== 8'h00 || bus_d.VGA_G !== 8'h00 || bus_d.VGA_B !== 8'h00) begin
      fails++; $display("FAIL midrst_color: got %h/%h/%h expected 00/00/00", bus_d.VGA_R, bus_d.VGA_G, bus_d.VGA_B);
    end
    repeat (2) tick();
    rst = 1'b0;
    #1;
    tests++; if (bus_d.frame_start !== 1'b1) begin fails++; $display("FAIL midrst_restart_fs: got %b expected 1", bus_d.frame_start); end
    tick();
    tests++; if (bus_d.hcount !== 11'd1) begin fails++; $display("FAIL midrst_restart_h: got %0d expected 1", bus_d.hcount); end
  endtask

  // Tiny timing, continuous strobes, one whole frame.
  task automatic test_small_frame();
    int h, v, fs_cnt, ls_cnt;
    logic e_hs, e_vs, e_de;
    logic [7:0] e_r, e_g;
    fs_cnt = 0; ls_cnt = 0;
    bus_s.enable = 1'b1;
    bus_s.pix_en = 1'b1;
    #1;
    tests++; if (bus_s.frame_start !== 1'b1) begin fails++; $display("FAIL small_first_fs: got %b expected 1", bus_s.frame_start); end
    for (int i = 0; i < 40; i++) begin
      tick();
      h = i % 8;
      v = i / 8;
      e_hs = (h == 5 || h == 6);
      e_vs = (v == 3);
      e_de = (h < 4 && v < 2);
      e_r  = e_de ? 8'hAA : 8'h00;
      e_g  = e_de ? 8'h11 : 8'h00;
      tests++; if (bus_s.hsync !== e_hs) begin fails++; $display("FAIL small_hsync (%0d,%0d): got %b expected %b", h, v, bus_s.hsync, e_hs); end
      tests++; if (bus_s.vsync !== e_vs) begin fails++; $display("FAIL small_vsync (%0d,%0d): got %b expected %b", h, v, bus_s.vsync, e_vs); end
      tests++; if (bus_s.de !== e_de) begin fails++; $display("FAIL small_de (%0d,%0d): got %b expected %b", h, v, bus_s.de, e_de); end
      tests++; if (bus_s.VGA_R !== e_r) begin fails++; $display("FAIL small_r (%0d,%0d): got %h expected %h", h, v, bus_s.VGA_R, e_r); end
      tests++; if (bus_s.VGA_G !== e_g) begin fails++; $display("FAIL small_g (%0d,%0d): got %h expected %h", h, v, bus_s.VGA_G, e_g); end
      if (bus_s.frame_start === 1'b1) fs_cnt++;
      if (bus_s.line_start === 1'b1) ls_cnt++;
    end
    tests++; if (bus_s.hcount !== 11'd0 || bus_s.vcount !== 11'd0) begin
      fails++; $display("FAIL small_frame_wrap: got (%0d,%0d) expected (0,0)", bus_s.hcount, bus_s.vcount);
    end
    tests++; if (fs_cnt != 1) begin fails++; $display("FAIL small_fs_count: got %0d expected 1", fs_cnt); end
    tests++; if (ls_cnt != 5) begin fails++; $display("FAIL small_ls_count: got %0d expected 5", ls_cnt); end
  endtask

  // Strobe every second clk: nothing may move on the idle cycles.
  task automatic test_half_rate();
    int fs_cnt;
    logic [10:0] prev_h, exp_h;
    logic [7:0] prev_r;
    logic prev_hs, prev_de;
    fs_cnt = 0;
    for (int c = 0; c < 80; c++) begin
      bus_s.pix_en = (c % 2 == 0);
      #1;
      if (bus_s.frame_start === 1'b1) fs_cnt++;
      prev_h = bus_s.hcount; prev_r = bus_s.VGA_R; prev_hs = bus_s.hsync; prev_de = bus_s.de;
      tick();
      if (c % 2 == 1) begin
        tests++;
        if (bus_s.hcount !== prev_h || bus_s.VGA_R !== prev_r || bus_s.hsync !== prev_hs || bus_s.de !== prev_de) begin
          fails++; $display("FAIL half_hold c=%0d: got h=%0d r=%h hs=%b de=%b expected h=%0d r=%h hs=%b de=%b",
                            c, bus_s.hcount, bus_s.VGA_R, bus_s.hsync, bus_s.de, prev_h, prev_r, prev_hs, prev_de);
        end
      end else begin
        exp_h = (prev_h == 11'd7) ? 11'd0 : prev_h + 11'd1;
        tests++; if (bus_s.hcount !== exp_h) begin fails++; $display("FAIL half_step c=%0d: got %0d expected %0d", c, bus_s.hcount, exp_h); end
      end
    end
    tests++; if (bus_s.hcount !== 11'd0 || bus_s.vcount !== 11'd0) begin
      fails++; $display("FAIL half_frame_wrap: got (%0d,%0d) expected (0,0)", bus_s.hcount, bus_s.vcount);
    end
    tests++; if (fs_cnt != 1) begin fails++; $display("FAIL half_fs_count: got %0d expected 1", fs_cnt); end
    bus_s.pix_en = 1'b1;
    #1;
    tests++; if (bus_s.frame_start !== 1'b1) begin fails++; $display("FAIL half_fs_period: got %b at clk 80 expected 1", bus_s.frame_start); end
  endtask

  task automatic test_enable_off();
    repeat (12) tick();
    tests++; if (bus_s.hcount !== 11'd4 || bus_s.vcount !== 11'd1) begin
      fails++; $display("FAIL en_pre_pos: got (%0d,%0d) expected (4,1)", bus_s.hcount, bus_s.vcount);
    end
    tests++; if (bus_s.de !== 1'b1 || bus_s.VGA_R !== 8'hAA) begin
      fails++; $display("FAIL en_pre_out: got de=%b r=%h expected de=1 r=aa", bus_s.de, bus_s.VGA_R);
    end
    bus_s.enable = 1'b0;
    bus_s.pix_en = 1'b0;
    tick();
    tests++; if (bus_s.hcount !== 11'd0 || bus_s.vcount !== 11'd0) begin
      fails++; $display("FAIL en_off_pos: got (%0d,%0d) expected (0,0)", bus_s.hcount, bus_s.vcount);
    end
    tests++; if (bus_s.de !== 1'b0 || bus_s.VGA_R !== 8'h00 || bus_s.hsync !== 1'b0 || bus_s.vsync !== 1'b0) begin
      fails++; $display("FAIL en_off_idle: got de=%b r=%h hs=%b vs=%b expected 0/00/0/0", bus_s.de, bus_s.VGA_R, bus_s.hsync, bus_s.vsync);
    end
    bus_s.pix_en = 1'b1;
    #1;
    tests++; if (bus_s.line_start !== 1'b0) begin fails++; $display("FAIL en_off_pulse: got %b expected 0", bus_s.line_start); end
    tick();
    tests++; if (bus_s.hcount !== 11'd0) begin fails++; $display("FAIL en_off_hold: got %0d expected 0", bus_s.hcount); end
    bus_s.enable = 1'b1;
    #1;
    tests++; if (bus_s.frame_start !== 1'b1) begin fails++; $display("FAIL en_restart_fs: got %b expected 1", bus_s.frame_start); end
    tick();
    tests++; if (bus_s.hcount !== 11'd1 || bus_s.de !== 1'b1 || bus_s.VGA_R !== 8'hAA) begin
      fails++; $display("FAIL en_restart_out: got h=%0d de=%b r=%h expected h=1 de=1 r=aa", bus_s.hcount, bus_s.de, bus_s.VGA_R);
    end
    repeat (5) tick();
    tests++; if (bus_s.hsync !== 1'b1) begin fails++; $display("FAIL en_pre2_hsync: got %b expected 1", bus_s.hsync); end
    bus_s.enable = 1'b0;
    tick();
    tests++; if (bus_s.hsync !== 1'b0 || bus_s.hcount !== 11'd0) begin
      fails++; $display("FAIL en_off2: got hs=%b h=%0d expected hs=0 h=0", bus_s.hsync, bus_s.hcount);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_first_strobe();
    test_hline();
    test_mid_reset();
    test_small_frame();
    test_half_rate();
    test_enable_off();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
